// File: rtl/definitions_pkg.sv
// Shared definitions for the image pipeline: frame geometry defaults and
// the 3x3 window types used by the window generator and the Gaussian stage.
package definitions_pkg;

  localparam int DEF_IMG_WIDTH  = 640;
  localparam int DEF_IMG_HEIGHT = 480;
  localparam int PIX_W          = 8;
  localparam int WIN_BYTES      = 9;
  localparam int WIN_W          = WIN_BYTES * PIX_W;

  typedef enum logic {FILL, RUN} win_state_t;

  typedef logic [PIX_W-1:0] pix_t;
  // Packed [r][c] so that element (r,c) lands at byte r*3+c of the flat bus.
  typedef pix_t [2:0][2:0]  win_t;

endpackage

// File: rtl/line_buffer.sv
// One-line delay: circular RAM with a single pointer, read-before-write, so
// dout is the sample written DEPTH enables earlier. Storage is not reset.
module line_buffer #(
  parameter int DEPTH  = 640,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     ptr_q, ptr_d;

  assign dout = mem_q[ptr_q];

  always_comb begin
    ptr_d = ptr_q;
    if (en) ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  always_ff @(posedge clk) begin
    if (en) mem_q[ptr_q] <= din;
  end

endmodule

// File: rtl/window_gen_3x3.sv
// Streaming 3x3 neighbourhood generator: raster pixels in, one registered
// window per interior pixel out (no border padding).
module window_gen_3x3
  import definitions_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] pixel_in,
  input  logic             pixel_in_valid,
  input  logic             sof_in,
  output logic [WIN_W-1:0] window_out,
  output logic             window_out_valid
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0] col_q, col_d, col_cur;
  logic [RW-1:0] row_q, row_d, row_cur;
  win_state_t    state_q, state_d;
  win_t          win_q, win_d;
  logic [WIN_W-1:0] wout_q, wout_d;
  logic          vld_q, vld_d;

  logic          line_end, frame_end, enter_run, run_now, emit;
  pix_t          lb1_out, lb2_out;
  pix_t [2:0]    new_col;

  line_buffer #(.DEPTH(IMG_WIDTH), .DATA_W(PIX_W)) u_lb1 (
    .clk (clk),
    .rst (rst),
    .en  (pixel_in_valid),
    .din (pixel_in),
    .dout(lb1_out)
  );

  line_buffer #(.DEPTH(IMG_WIDTH), .DATA_W(PIX_W)) u_lb2 (
    .clk (clk),
    .rst (rst),
    .en  (pixel_in_valid),
    .din (lb1_out),
    .dout(lb2_out)
  );

  // Position of the pixel on the input this cycle; sof overrides to (0,0).
  always_comb begin
    col_cur   = sof_in ? '0 : col_q;
    row_cur   = sof_in ? '0 : row_q;
    line_end  = (col_cur == COL_LAST);
    frame_end = line_end && (row_cur == ROW_LAST);
    enter_run = (row_cur == RW'(2)) && (col_cur == '0);
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (pixel_in_valid) begin
      col_d = line_end ? '0 : col_cur + 1'b1;
      if (line_end) row_d = frame_end ? '0 : row_cur + 1'b1;
      else          row_d = row_cur;
    end
  end

  always_comb begin
    state_d = state_q;
    run_now = 1'b0;
    case (state_q)
      FILL: begin
        if (pixel_in_valid && enter_run) begin
          state_d = RUN;
          run_now = 1'b1;
        end
      end
      RUN: begin
        run_now = !sof_in;
        if (pixel_in_valid && (sof_in || frame_end)) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  assign emit = pixel_in_valid && run_now && (col_cur >= CW'(2));

  // Newest column enters on the right; top row is the oldest line.
  assign new_col[0] = lb2_out;
  assign new_col[1] = lb1_out;
  assign new_col[2] = pixel_in;

  always_comb begin
    win_d = win_q;
    if (pixel_in_valid) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
        win_d[r][2] = new_col[r];
      end
    end
  end

  always_comb begin
    vld_d  = emit;
    wout_d = emit ? WIN_W'(win_d) : wout_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      state_q <= FILL;
      win_q   <= '0;
      wout_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      state_q <= state_d;
      win_q   <= win_d;
      wout_q  <= wout_d;
      vld_q   <= vld_d;
    end
  end

  assign window_out       = wout_q;
  assign window_out_valid = vld_q;

endmodule

// File: tb/tb_window_gen_3x3.sv
// Directed bench for window_gen_3x3 on a 5x4 frame with pixel = base + row*16 + col.
module tb_window_gen_3x3;

  localparam int W = 5;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pixel_in;
  logic        pixel_in_valid;
  logic        sof_in;
  logic [71:0] window_out;
  logic        window_out_valid;

  int          n_chk = 0;
  int          n_err = 0;
  int          n_strobe = 0;
  logic [71:0] last_win;

  window_gen_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk             (clk),
    .rst             (rst),
    .pixel_in        (pixel_in),
    .pixel_in_valid  (pixel_in_valid),
    .sof_in          (sof_in),
    .window_out      (window_out),
    .window_out_valid(window_out_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (window_out_valid === 1'b1) n_strobe++;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] win_at(input int base, input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int rr = 0; rr < 3; rr++)
      for (int cc = 0; cc < 3; cc++)
        w[(rr*3+cc)*8 +: 8] = 8'(base + (r-2+rr)*16 + (c-2+cc));
    return w;
  endfunction

  // One clock: apply inputs, step past the edge, check the registered outputs.
  task automatic drive(input logic v, input logic s, input logic [7:0] p, input logic r_rst,
                       input logic exp_v, input logic [71:0] exp_w, input string tag);
    pixel_in = p; pixel_in_valid = v; sof_in = s; rst = r_rst;
    @(posedge clk); #1;
    if (r_rst) last_win = '0;
    else if (exp_v) last_win = exp_w;
    chk({tag, " valid"}, 72'(window_out_valid), 72'(exp_v));
    chk({tag, " win"}, window_out, last_win);
  endtask

  task automatic idle(input string tag);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, '0, tag);
  endtask

  task automatic frame(input int base, input logic sof0, input logic gap, input int npix);
    for (int i = 0; i < npix; i++) begin
      int r, c;
      r = i / W;
      c = i % W;
      drive(1'b1, sof0 && (i == 0), 8'(base + r*16 + c), 1'b0, (r >= 2) && (c >= 2),
            win_at(base, r, c), $sformatf("px b%0h r%0d c%0d", base, r, c));
      if (base == 0 && r == 2 && c == 2)
        chk("first window", window_out, 72'h22_21_20_12_11_10_02_01_00);
      if (gap) idle($sformatf("gap r%0d c%0d", r, c));
    end
  endtask

  initial begin
    int s;
    last_win = '0;
    pixel_in = '0; pixel_in_valid = 1'b0; sof_in = 1'b0; rst = 1'b1;

    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, '0, "reset0");
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, '0, "reset1");
    for (int i = 0; i < 20; i++) idle($sformatf("idle%0d", i));

    // continuous frame
    s = n_strobe;
    frame(0, 1'b0, 1'b0, W*H);
    idle("post f1");
    chk("f1 strobes", 72'(n_strobe - s), 72'd6);
    chk("last window", window_out, 72'h34_33_32_24_23_22_14_13_12);

    // valid toggling every cycle
    s = n_strobe;
    frame(0, 1'b0, 1'b1, W*H);
    idle("post gap");
    chk("gap strobes", 72'(n_strobe - s), 72'd6);

    // back-to-back frames, no sof
    s = n_strobe;
    frame(0, 1'b0, 1'b0, W*H);
    frame(0, 1'b0, 1'b0, W*H);
    idle("post b2b");
    chk("b2b strobes", 72'(n_strobe - s), 72'd12);

    // abandoned frame: sof lands where (2,1) would be
    s = n_strobe;
    frame(8'h80, 1'b0, 1'b0, 2*W + 1);
    frame(0, 1'b1, 1'b0, W*H);
    idle("post sof");
    chk("sof strobes", 72'(n_strobe - s), 72'd6);

    // reset pulse on pixel (3,0), then a frame without sof
    frame(0, 1'b0, 1'b0, 3*W);
    drive(1'b1, 1'b0, 8'h30, 1'b1, 1'b0, '0, "rst pulse");
    s = n_strobe;
    frame(0, 1'b0, 1'b0, W*H);
    idle("post rst");
    chk("rst strobes", 72'(n_strobe - s), 72'd6);

    // sof coinciding with the natural wrap
    s = n_strobe;
    frame(0, 1'b1, 1'b0, W*H);
    idle("post wrap sof");
    chk("wrap sof strobes", 72'(n_strobe - s), 72'd6);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
